branch_predictor_2bit: RTL and testbench
========================================

Name: branch_predictor_2bit

Overview:
- Branch prediction unit for the pipelined core; produces the `prediction` bit that the hazard detection unit compares against the resolved outcome to raise flush.
- Holds a table of 2-bit saturating counters indexed by the fetch PC. Lookup happens in IF.
- Carries the prediction and table index alongside the instruction into ID, honouring stall/flush.
- Trains the table when the branch resolves in ID, and counts branches and mispredicts.

Parameters:
- INDEX_BITS, 6, log2 of table entries (64 counters); index = pc[INDEX_BITS+1:2].
- INIT_STATE, 2'b01, counter value loaded on reset (weakly not-taken).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- if_pc  input  32  PC of the instruction in IF
- stall  input  1  from hazard unit; holds the IF/ID stage
- flush  input  1  from hazard unit; squashes the instruction entering ID
- id_branch  input  1  instruction currently in ID is a conditional branch
- id_taken  input  1  resolved outcome from the ID comparator (PCSrcD)
- prediction  output  1  IF-stage prediction for if_pc (combinational)
- id_prediction  output  1  prediction carried with the ID instruction
- mispredict  output  1  ID branch resolved opposite to its prediction
- branch_count  output  32  resolved branches since reset
- mispredict_count  output  32  mispredicts since reset

Behaviour:
- Clock/reset: single clock clk; rst asynchronous, active-high.
- On reset:
  - all counters = INIT_STATE;
  - id_prediction = 0, id_index = 0, id_valid = 0;
  - both counts = 0;
  - GHR = 0 when GSHARE_EN is defined.
- Lookup:
  - if_idx = if_pc[INDEX_BITS+1:2], or its gshare form.
  - prediction = table[if_idx][1], purely combinational, zero latency.
- IF→ID register, priority order:
  1. stall=1: id_prediction, id_index and id_valid hold. Stall wins over flush.
  2. Else flush=1: id_valid ← 0, id_prediction ← 0.
  3. Else: id_valid ← 1, id_prediction ← prediction, id_index ← if_idx.
- Resolve condition: upd = id_valid & id_branch & ~stall.
  - Exactly one update per branch, even if that branch is held for several stalled cycles.
- mispredict = upd & (id_prediction != id_taken), combinational.
- Training on upd, at the clock edge:
  - id_taken=1: counter increments, saturating at 3.
  - id_taken=0: counter decrements, saturating at 0.
  - Only table[id_index] changes.
- Read/write collision: if if_idx == id_index in the same cycle, prediction returns the pre-update value; the new value is visible next cycle.
- Counts:
  - branch_count increments on upd.
  - mispredict_count increments on mispredict.
  - Both wrap modulo 2^32.
- Flush caused by a mispredict does not cancel that branch's own update; only the next instruction is squashed.
- Reset mid-operation: all state returns to reset values immediately; no update completes.

Optional Feature:
- Macro: BPU_GSHARE_EN.
- Defined:
  - Adds an INDEX_BITS-wide global history register GHR.
  - if_idx = if_pc[INDEX_BITS+1:2] ^ GHR.
  - On upd, GHR ← {GHR[INDEX_BITS-2:0], id_taken}.
  - The stored id_index (the XORed value) is used for training.
- Undefined:
  - No GHR; indexing is by PC bits only.

Test Plan:
- Reset, then if_pc=0x40 → prediction=0; after 2 cycles with no stall/flush, id_prediction=0 and both counts=0.
- Branch at 0x40 with id_branch=1, id_taken=1, resolved twice → counter goes 01→10→11:
  - prediction=1 on the next fetch of 0x40;
  - branch_count=2, mispredict_count=1.
- Saturation: three further taken resolves at 0x40 leave the counter at 3. One not-taken resolve → counter=2, prediction still 1, mispredict=1 that cycle.
- Stall held 3 cycles with a branch in ID → id_prediction stable, branch_count increments once (when the stall drops).
- flush=1 with stall=0 → next cycle id_valid=0; id_branch=1 then causes no update and no count change. The same with stall=1 → the ID contents are held.
- Collision: if_pc index equals id_index during a taken update from 01 → prediction=0 that cycle, 1 the next. With BPU_GSHARE_EN defined, after one taken resolve GHR=1, so if_pc=0x40 indexes entry 0x11.

Source files
------------

// File: rtl/branch_predictor_2bit.sv
// Bimodal branch predictor: a table of 2-bit saturating counters looked up in IF and trained in ID.
// Optional gshare indexing is enabled by defining BPU_GSHARE_EN.
module branch_predictor_2bit #(
  parameter int         INDEX_BITS = 6,
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_branch,
  input  logic        id_taken,
  output logic        prediction,
  output logic        id_prediction,
  output logic        mispredict,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [1:0]            ctr_value [ENTRIES];
  logic [INDEX_BITS-1:0] pc_idx;
  logic [INDEX_BITS-1:0] if_idx;
  logic [INDEX_BITS-1:0] id_index_reg;
  logic                  id_valid_reg;
  logic                  id_prediction_reg;
  logic                  upd;
  logic [1:0]            train_cur;
  logic [1:0]            train_next;
  logic [31:0]           branch_count_reg;
  logic [31:0]           mispredict_count_reg;
  logic                  unused_pc_bits;

  assign pc_idx         = if_pc[INDEX_BITS+1:2];
  assign unused_pc_bits = ^{if_pc[31:INDEX_BITS+2], if_pc[1:0]};

`ifdef BPU_GSHARE_EN
  logic [INDEX_BITS-1:0] ghr_reg;

  assign if_idx = pc_idx ^ ghr_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_reg <= '0;
    end else if (upd) begin
      ghr_reg <= {ghr_reg[INDEX_BITS-2:0], id_taken};
    end
  end
`else
  assign if_idx = pc_idx;
`endif

  // Reads the registered table, so a same-cycle update is only seen next cycle.
  assign prediction = ctr_value[if_idx][1];

  // Gating with ~stall makes a branch held in ID train exactly once.
  assign upd        = id_valid_reg & id_branch & ~stall;
  assign mispredict = upd & (id_prediction_reg != id_taken);

  assign train_cur = ctr_value[id_index_reg];

  always_comb begin
    train_next = train_cur;
    if (id_taken) begin
      if (train_cur != 2'b11) train_next = train_cur + 2'd1;
    end else begin
      if (train_cur != 2'b00) train_next = train_cur - 2'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      localparam logic [INDEX_BITS-1:0] ENTRY_IDX = INDEX_BITS'(gi);
      logic [1:0] ctr_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ctr_reg <= INIT_STATE;
        end else if (upd && (id_index_reg == ENTRY_IDX)) begin
          ctr_reg <= train_next;
        end
      end

      assign ctr_value[gi] = ctr_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid_reg      <= 1'b0;
      id_prediction_reg <= 1'b0;
      id_index_reg      <= '0;
    end else if (stall) begin
      id_valid_reg      <= id_valid_reg;
      id_prediction_reg <= id_prediction_reg;
      id_index_reg      <= id_index_reg;
    end else if (flush) begin
      // The index is left alone; it is ignored while id_valid_reg is low.
      id_valid_reg      <= 1'b0;
      id_prediction_reg <= 1'b0;
    end else begin
      id_valid_reg      <= 1'b1;
      id_prediction_reg <= prediction;
      id_index_reg      <= if_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_count_reg     <= '0;
      mispredict_count_reg <= '0;
    end else begin
      if (upd)        branch_count_reg     <= branch_count_reg + 32'd1;
      if (mispredict) mispredict_count_reg <= mispredict_count_reg + 32'd1;
    end
  end

  assign id_prediction    = id_prediction_reg;
  assign branch_count     = branch_count_reg;
  assign mispredict_count = mispredict_count_reg;

endmodule

// File: tb/tb_branch_predictor_2bit.sv
// Randomized bench for branch_predictor_2bit, checked every cycle against a counter-table model
// plus directed scenarios with hand-computed expectations.
module tb_branch_predictor_2bit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        stall, flush, id_branch, id_taken;
  logic        prediction, id_prediction, mispredict;
  logic [31:0] branch_count, mispredict_count;

  int total = 0;
  int bad   = 0;

  // Reference model: counter strengths 0..3, IF/ID contents, counts, history.
  int          m_ctr [64];
  bit          m_valid, m_pred;
  int          m_idx;
  int unsigned m_bc, m_mc;
  int          m_ghr;

  branch_predictor_2bit dut (
    .clk              (clk),
    .rst              (rst),
    .if_pc            (if_pc),
    .stall            (stall),
    .flush            (flush),
    .id_branch        (id_branch),
    .id_taken         (id_taken),
    .prediction       (prediction),
    .id_prediction    (id_prediction),
    .mispredict       (mispredict),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) & 32'h3F) ^ m_ghr;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_ctr[i] = 1;
    m_valid = 0; m_pred = 0; m_idx = 0;
    m_bc = 0; m_mc = 0; m_ghr = 0;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    bit upd_e, mis_e;
    upd_e = m_valid && id_branch && !stall;
    mis_e = upd_e && (m_pred != id_taken);
    cmp("prediction", {31'd0, prediction}, {31'd0, m_ctr[idx_of(if_pc)] >= 2});
    cmp("id_prediction", {31'd0, id_prediction}, {31'd0, m_pred});
    cmp("mispredict", {31'd0, mispredict}, {31'd0, mis_e});
    cmp("branch_count", branch_count, m_bc);
    cmp("mispredict_count", mispredict_count, m_mc);
  endtask

  // Apply one clock edge to the model, using the inputs that were present before it.
  task automatic model_update();
    bit upd_e, pred_now;
    int idx_now;
    upd_e    = m_valid && id_branch && !stall;
    idx_now  = idx_of(if_pc);
    pred_now = m_ctr[idx_now] >= 2;
    if (upd_e) begin
      if (m_pred != id_taken) m_mc++;
      m_bc++;
      m_ctr[m_idx] = id_taken ? ((m_ctr[m_idx] < 3) ? m_ctr[m_idx] + 1 : 3)
                              : ((m_ctr[m_idx] > 0) ? m_ctr[m_idx] - 1 : 0);
`ifdef BPU_GSHARE_EN
      m_ghr = ((m_ghr << 1) | int'(id_taken)) & 63;
`endif
    end
    if (!stall) begin
      if (flush) begin
        m_valid = 0; m_pred = 0;
      end else begin
        m_valid = 1; m_pred = pred_now; m_idx = idx_now;
      end
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic [31:0] pc, input logic st, input logic fl,
                      input logic br, input logic tk);
    if_pc = pc; stall = st; flush = fl; id_branch = br; id_taken = tk;
    #1;
    check_outputs();
    $display("cycle pc=%08h st=%0b fl=%0b br=%0b tk=%0b pred=%0b idp=%0b mis=%0b bc=%0d mc=%0d",
             pc, st, fl, br, tk, prediction, id_prediction, mispredict, branch_count, mispredict_count);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; if_pc = 32'h40; stall = 0; flush = 0; id_branch = 0; id_taken = 0;
    model_reset();
    @(negedge clk);
    cmp("reset_prediction", {31'd0, prediction}, 32'd0);
    cmp("reset_id_prediction", {31'd0, id_prediction}, 32'd0);
    cmp("reset_branch_count", branch_count, 32'd0);
    cmp("reset_mispredict_count", mispredict_count, 32'd0);
    check_outputs();
    rst = 1'b0;

`ifdef BPU_GSHARE_EN
    step(32'h40, 0, 0, 0, 0);
    step(32'h80, 0, 0, 1, 1);
    if_pc = 32'h40; #1;
    cmp("gshare_idx_0x11_pred", {31'd0, prediction}, 32'd0);
    cmp("gshare_model_idx", idx_of(32'h40), 32'h11);
`else
    step(32'h40, 0, 0, 0, 0);
    step(32'h40, 0, 0, 0, 0);
    cmp("idle_id_prediction", {31'd0, id_prediction}, 32'd0);
    cmp("idle_branch_count", branch_count, 32'd0);
    cmp("idle_mispredict_count", mispredict_count, 32'd0);

    // Two taken resolves at 0x40: 01 -> 10 -> 11, only the first mispredicts.
    step(32'h80, 0, 0, 1, 1);
    step(32'h40, 0, 0, 0, 0);
    step(32'h80, 0, 0, 1, 1);
    cmp("train_branch_count", branch_count, 32'd2);
    cmp("train_mispredict_count", mispredict_count, 32'd1);
    if_pc = 32'h40; #1;
    cmp("train_prediction", {31'd0, prediction}, 32'd1);

    // Saturation, then a single not-taken resolve.
    repeat (3) begin
      step(32'h40, 0, 0, 0, 0);
      step(32'h80, 0, 0, 1, 1);
    end
    cmp("sat_branch_count", branch_count, 32'd5);
    cmp("sat_mispredict_count", mispredict_count, 32'd1);
    step(32'h40, 0, 0, 0, 0);
    step(32'h80, 0, 0, 1, 0);
    cmp("nt_mispredict_count", mispredict_count, 32'd2);
    if_pc = 32'h40; #1;
    cmp("nt_prediction", {31'd0, prediction}, 32'd1);

    // Stall held three cycles: one update, after the stall drops.
    step(32'h40, 0, 0, 0, 0);
    repeat (3) step(32'h80, 1, 0, 1, 1);
    cmp("stall_branch_count", branch_count, 32'd6);
    cmp("stall_id_prediction", {31'd0, id_prediction}, 32'd1);
    step(32'h80, 0, 0, 1, 1);
    cmp("unstall_branch_count", branch_count, 32'd7);

    // Flush squashes; flush under stall holds.
    step(32'h40, 0, 1, 0, 0);
    cmp("flush_id_prediction", {31'd0, id_prediction}, 32'd0);
    step(32'h40, 0, 0, 1, 1);
    cmp("flush_branch_count", branch_count, 32'd7);
    step(32'h80, 1, 1, 0, 0);
    cmp("stallflush_id_prediction", {31'd0, id_prediction}, 32'd1);
    step(32'h80, 0, 0, 1, 0);
    cmp("stallflush_branch_count", branch_count, 32'd8);
    cmp("stallflush_mispredict_count", mispredict_count, 32'd3);

    // Collision on entry 0 (pc 0x100), counter at 01.
    step(32'h100, 0, 0, 0, 0);
    cmp("collide_before", {31'd0, prediction}, 32'd0);
    step(32'h100, 0, 0, 1, 1);
    cmp("collide_loaded_old", {31'd0, id_prediction}, 32'd0);
    cmp("collide_after", {31'd0, prediction}, 32'd1);
`endif

    // Randomized traffic with occasional mid-run resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        $display("cycle reset bc=%0d mc=%0d", branch_count, mispredict_count);
        @(negedge clk);
        rst = 1'b0;
      end else begin
        step({22'd0, 8'($urandom_range(0, 255)), 2'b00},
             $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 15,
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
